unidad_riesgos: RTL
===================

# unidad_riesgos

Pipeline hazard and flow controller for the 5-stage MIPS core. Sits beside the decoder's control unit and drives the PC, IF/ID and downstream pipeline-register enables and flushes. It resolves load-use hazards, branch-taken and jump redirects, and wait states from a slow data memory. Outputs are combinational from the current inputs and registered state; only the FSM, the wait counter and the optional performance counters are sequential.

## Interface
- WAIT_MAX, 15, maximum number of frozen cycles per memory access before forced release (legal range 2..255).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- id_op  in  6  opcode of the instruction in IF/ID.
- id_rs, id_rt  in  5 each  source register fields in IF/ID.
- ex_mem_read  in  1  MemRead bit of the tM bundle held in ID/EX.
- ex_rt  in  5  rt (load destination) held in ID/EX.
- mem_branch, mem_zero  in  1 each  Branch bit and ALU zero held in EX/MEM.
- mem_read, mem_write  in  1 each  data-memory access issued by the MEM stage.
- mem_ready  in  1  data-memory completion for the current access.
- id_jump  in  1  jump output of the control unit for the IF/ID instruction.
- pc_write, ifid_write, pipe_write  out  1 each  enables: PC; IF/ID; ID/EX, EX/MEM and MEM/WB.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all-zero tWB/tM/tEX, nop) at the next edge.
- pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- state  out  2  FSM state (debug).
- mem_err  out  1  sticky memory-timeout flag.

## Operation
- FSM states: RUN = 00, WAIT = 01, BUBBLE = 10.
- rs-user: every opcode except 000010. rt-user: 000000, 101011, 000100.
- Load-use condition: ex_mem_read, ex_rt != 0, and either ex_rt == id_rs for an rs-user or ex_rt == id_rt for an rt-user.
- Memory busy: (mem_read | mem_write) & !mem_ready.
- Per-cycle priority, highest first:
  - rst: all enables 0, all flushes 1, pc_sel 00, state RUN, wait counter 0, mem_err 0.
  - Freeze (memory busy in RUN, or in WAIT without ready or timeout): all enables 0, no flushes, pc_sel 00.
  - Branch taken (mem_branch & mem_zero): pc_sel 01, all three flushes 1, enables 1.
  - Load-use in RUN: pc_write 0, ifid_write 0, idex_flush 1, pipe_write 1. Next state is BUBBLE.
  - Jump (id_jump): pc_sel 10, ifid_flush 1, enables 1.
  - Otherwise: enables 1, no flushes, pc_sel 00.
- BUBBLE: load-use detection is suppressed for this one cycle; all other rules apply. Next state is RUN unless memory is busy, in which case it is WAIT.
- WAIT: entered at the edge after a freeze in RUN or BUBBLE. The wait counter is cleared on entry.
  - mem_ready = 1: release (normal rules apply this cycle), next state RUN.
  - mem_ready = 0 and counter == WAIT_MAX-1: forced release, mem_err is set at the edge, next state RUN.
  - Otherwise the counter increments.
- Branch and load-use in the same cycle: the branch wins and no stall is taken. Branch and jump in the same cycle: the branch wins.

## Timing
- Zero-latency decisions: enables, flushes and pc_sel respond in the same cycle as the inputs.
- State, the wait counter and mem_err update on the rising edge of clk.
- The load-use stall is exactly 1 cycle.
- A memory access without ready costs at most WAIT_MAX frozen cycles, with release in cycle WAIT_MAX relative to the first frozen cycle.
- rst asserted mid-WAIT: outputs take reset values in that cycle; RUN from the next cycle.

## Configuration
- RIESGOS_PERF_EN defined: adds output ports stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments on every non-reset cycle with pc_write = 0.
  - flush_cnt increments on every branch-taken or jump redirect.
  - Both saturate at 16'hFFFF and clear on rst.
- RIESGOS_PERF_EN undefined: these ports and registers are absent.

## Test plan
- Reset: rst=1 for 2 cycles → pc_write=ifid_write=pipe_write=0, all flushes=1, state=00, mem_err=0.
- Load-use: ex_mem_read=1, ex_rt=8, id_op=000000, id_rt=8 → pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle, state=10, next cycle with the same inputs no stall. Repeat with ex_rt=0 → no stall.
- Branch vs jump: mem_branch=1, mem_zero=1, id_jump=1 → pc_sel=01, three flushes=1. With mem_zero=0 → pc_sel=10, ifid_flush=1 only.
- Memory wait: mem_read=1, mem_ready=0 for cycles 0–2, 1 in cycle 3 → pc_write=pipe_write=0 in cycles 0–2, 1 in cycle 3; state 00,01,01,01 then 00.
- Timeout: WAIT_MAX=4, mem_ready held 0 → frozen cycles 0–3, forced release in cycle 4, mem_err=1 from cycle 5 and held until rst.
- Perf (RIESGOS_PERF_EN): run the load-use test plus 2 branch redirects → stall_cnt=1, flush_cnt=2. Preload a value near saturation → stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/unidad_riesgos.sv
// unidad_riesgos: hazard and flow controller for the 5-stage MIPS pipeline.
// Purpose : resolves load-use stalls, branch/jump redirects and slow data-memory
//           wait states by driving PC / pipeline-register enables, flushes and pc_sel.
// Latency : zero-latency decisions; only FSM state, wait counter, mem_err (and the
//           optional perf counters) are registered on the rising edge of clk.
// Backpressure: a busy data memory freezes every enable for at most WAIT_MAX cycles,
//           after which the access is force-released and mem_err latches.
// Optional: define RIESGOS_PERF_EN to add stall_cnt[15:0] and flush_cnt[15:0].
// Ports   : clk, rst (sync, active-high); IF/ID fields id_op/id_rs/id_rt/id_jump;
//           ID/EX ex_mem_read/ex_rt; EX/MEM mem_branch/mem_zero; MEM-stage
//           mem_read/mem_write/mem_ready; outputs pc_write, ifid_write, pipe_write,
//           ifid_flush, idex_flush, exmem_flush, pc_sel, state, mem_err.
module unidad_riesgos #(
   parameter int WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] id_op,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic       mem_branch,
   input  logic       mem_zero,
   input  logic       mem_read,
   input  logic       mem_write,
   input  logic       mem_ready,
   input  logic       id_jump,
   output logic       pc_write,
   output logic       ifid_write,
   output logic       pipe_write,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic       exmem_flush,
   output logic [1:0] pc_sel,
   output logic [1:0] state,
   output logic       mem_err
`ifdef RIESGOS_PERF_EN
   ,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_WAIT   = 2'b01,
      ST_BUBBLE = 2'b10
   } state_t;

   localparam logic [1:0] SEL_PC4 = 2'b00;
   localparam logic [1:0] SEL_BR  = 2'b01;
   localparam logic [1:0] SEL_JMP = 2'b10;
   localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

   state_t     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       mem_err_q, mem_err_d;

   logic mem_busy;
   logic timeout;
   logic freeze;
   logic branch_taken;
   logic rs_user, rt_user;
   logic load_use;
   logic lu_stall;
   logic redirect;

   // Hazard terms
   always_comb begin
      mem_busy     = (mem_read | mem_write) & ~mem_ready;
      branch_taken = mem_branch & mem_zero;
      // j (000010) reads no register; R-type, sw and beq also read rt.
      rs_user      = (id_op != 6'b000010);
      rt_user      = (id_op == 6'b000000) | (id_op == 6'b101011) | (id_op == 6'b000100);
      load_use     = ex_mem_read & (ex_rt != 5'd0) &
                     ((rs_user & (ex_rt == id_rs)) | (rt_user & (ex_rt == id_rt)));
      // Detection only in RUN: BUBBLE is the one-cycle stall itself, and a
      // WAIT release simply resumes the pipeline.
      lu_stall     = (state_q == ST_RUN) & load_use;
      timeout      = (state_q == ST_WAIT) & ~mem_ready & (wait_cnt_q == CNT_LAST);
      freeze       = (state_q == ST_WAIT) ? (~mem_ready & ~timeout) : mem_busy;
   end

   // Next state and outputs
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_err_d   = mem_err_q;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      pipe_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      pc_sel      = SEL_PC4;
      redirect    = 1'b0;

      if (rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         pipe_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         state_d     = ST_RUN;
         wait_cnt_d  = 8'd0;
         mem_err_d   = 1'b0;
      end else if (freeze) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_write = 1'b0;
         state_d    = ST_WAIT;
         // Counter restarts on entry, counts only while already waiting.
         wait_cnt_d = (state_q == ST_WAIT) ? (wait_cnt_q + 8'd1) : 8'd0;
      end else begin
         state_d    = ST_RUN;
         wait_cnt_d = 8'd0;
         if (timeout) begin
            mem_err_d = 1'b1;
         end
         if (branch_taken) begin
            pc_sel      = SEL_BR;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            redirect    = 1'b1;
         end else if (lu_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_d    = ST_BUBBLE;
         end else if (id_jump) begin
            pc_sel     = SEL_JMP;
            ifid_flush = 1'b1;
            redirect   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= 8'd0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   // Reset forces the visible debug/status values in the same cycle.
   always_comb begin
      state   = rst ? ST_RUN : state_q;
      mem_err = rst ? 1'b0 : mem_err_q;
   end

`ifdef RIESGOS_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (rst) begin
         stall_cnt_d = 16'd0;
         flush_cnt_d = 16'd0;
      end else begin
         if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
         end
         if (redirect && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
         end
      end
      stall_cnt = rst ? 16'd0 : stall_cnt_q;
      flush_cnt = rst ? 16'd0 : flush_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
`endif

endmodule
